// File: rtl/model_read_heads_pkg.sv
// Shared definitions for the read_heads group (read keys, read strength, read modes).
//   rh_state_e   : four-state transfer FSM used by every read-head streamer
//   ZERO_CONTROL : all-zero constant for index counters (cast down to CONTROL_SIZE)
//   ONE_CONTROL  : increment / "size minus one" constant for index counters
package model_read_heads_pkg;

  typedef enum logic [1:0] {
    STARTER = 2'd0,
    INPUT_I = 2'd1,
    INPUT_K = 2'd2,
    ENDER   = 2'd3
  } rh_state_e;

  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;

endpackage

// File: rtl/model_read_keys_if.sv
// Handshake/bus bundle of the read-key streamer.
//   START / READY                    : transfer start pulse and completion pulse
//   K_IN_I_ENABLE / K_IN_K_ENABLE    : producer marks row start / element valid
//   K_OUT_I_ENABLE / K_OUT_K_ENABLE  : request strobes towards the producer
//   SIZE_R_IN / SIZE_W_IN            : matrix dimensions R (rows) and W (elements per row)
//   K_IN / K_OUT                     : key element in, last accepted key element out
// master = controller/producer side, slave = streamer side.
interface model_read_keys_if #(
  parameter int DATA_SIZE = 64
) ();

  logic                 START;
  logic                 READY;
  logic                 K_IN_I_ENABLE;
  logic                 K_IN_K_ENABLE;
  logic                 K_OUT_I_ENABLE;
  logic                 K_OUT_K_ENABLE;
  logic [DATA_SIZE-1:0] SIZE_R_IN;
  logic [DATA_SIZE-1:0] SIZE_W_IN;
  logic [DATA_SIZE-1:0] K_IN;
  logic [DATA_SIZE-1:0] K_OUT;

  modport master (
    output START, K_IN_I_ENABLE, K_IN_K_ENABLE, SIZE_R_IN, SIZE_W_IN, K_IN,
    input  READY, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
  );

  modport slave (
    input  START, K_IN_I_ENABLE, K_IN_K_ENABLE, SIZE_R_IN, SIZE_W_IN, K_IN,
    output READY, K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT
  );

endinterface

// File: rtl/model_index_2d_counter.sv
// Row/element index pair for streaming an R x W matrix in row-major order.
//   clk, rst_n         : clock, synchronous active-low reset
//   clear_i            : return both indices to zero (has priority over advance)
//   advance_i          : step to the next element, wrapping the element index into the next row
//   size_r_i, size_w_i : matrix dimensions; only meaningful when both are non-zero
//   last_i_o, last_k_o : current row is the last row / current element is the last of its row
module model_index_2d_counter
  import model_read_heads_pkg::*;
#(
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    advance_i,
  input  logic [CONTROL_SIZE-1:0] size_r_i,
  input  logic [CONTROL_SIZE-1:0] size_w_i,
  output logic                    last_i_o,
  output logic                    last_k_o
);

  localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);
  localparam logic [CONTROL_SIZE-1:0] ONE_C  = CONTROL_SIZE'(ONE_CONTROL);

  logic [CONTROL_SIZE-1:0] index_i_q, index_i_d;
  logic [CONTROL_SIZE-1:0] index_k_q, index_k_d;

  assign last_i_o = (index_i_q == size_r_i - ONE_C);
  assign last_k_o = (index_k_q == size_w_i - ONE_C);

  always_comb begin
    index_i_d = index_i_q;
    index_k_d = index_k_q;
    if (clear_i) begin
      index_i_d = ZERO_C;
      index_k_d = ZERO_C;
    end else if (advance_i) begin
      if (last_k_o) begin
        index_k_d = ZERO_C;
        index_i_d = index_i_q + ONE_C;
      end else begin
        index_k_d = index_k_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index_i_q <= ZERO_C;
      index_k_q <= ZERO_C;
    end else begin
      index_i_q <= index_i_d;
      index_k_q <= index_k_d;
    end
  end

endmodule

// File: rtl/model_read_keys.sv
// Read-key streamer: requests the R x W read-key matrix element by element from the
// read_heads producer and forwards each accepted element on K_OUT.
//   CLK, RST : clock, synchronous active-low reset
//   bus      : slave side of model_read_keys_if (START/READY, request strobes,
//              producer enables, sizes, K_IN/K_OUT)
// Each element costs a request cycle pair: accept (INPUT_I/INPUT_K) then ENDER, which
// decides the next request, so throughput is at best one element per two cycles.
module model_read_keys
  import model_read_heads_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic             CLK,
  input  logic             RST,
  model_read_keys_if.slave bus
);

  localparam logic [CONTROL_SIZE-1:0] ZERO_C = CONTROL_SIZE'(ZERO_CONTROL);

  rh_state_e               state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    req_i_q, req_i_d;
  logic                    req_k_q, req_k_d;
  logic [DATA_SIZE-1:0]    k_out_q, k_out_d;
  logic [CONTROL_SIZE-1:0] size_r_q, size_r_d;
  logic [CONTROL_SIZE-1:0] size_w_q, size_w_d;
  logic                    zero_q, zero_d;

  logic                    cnt_clear;
  logic                    cnt_advance;
  logic                    last_i;
  logic                    last_k;
  logic [CONTROL_SIZE-1:0] size_r_in;
  logic [CONTROL_SIZE-1:0] size_w_in;

  // Sizes are truncated to the counter width before any comparison.
  assign size_r_in = CONTROL_SIZE'(bus.SIZE_R_IN);
  assign size_w_in = CONTROL_SIZE'(bus.SIZE_W_IN);

  assign bus.READY          = ready_q;
  assign bus.K_OUT_I_ENABLE = req_i_q;
  assign bus.K_OUT_K_ENABLE = req_k_q;
  assign bus.K_OUT          = k_out_q;

  model_index_2d_counter #(
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_index (
    .clk       (CLK),
    .rst_n     (RST),
    .clear_i   (cnt_clear),
    .advance_i (cnt_advance),
    .size_r_i  (size_r_q),
    .size_w_i  (size_w_q),
    .last_i_o  (last_i),
    .last_k_o  (last_k)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    req_i_d     = 1'b0;
    req_k_d     = 1'b0;
    k_out_d     = k_out_q;
    size_r_d    = size_r_q;
    size_w_d    = size_w_q;
    zero_d      = zero_q;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    unique case (state_q)
      STARTER: begin
        // READY is still high in the first idle cycle; a START there is dropped.
        if (bus.START && !ready_q) begin
          size_r_d  = size_r_in;
          size_w_d  = size_w_in;
          cnt_clear = 1'b1;
          if ((size_r_in == ZERO_C) || (size_w_in == ZERO_C)) begin
            zero_d  = 1'b1;
            state_d = ENDER;
          end else begin
            zero_d  = 1'b0;
            req_i_d = 1'b1;
            req_k_d = 1'b1;
            state_d = INPUT_I;
          end
        end
      end

      INPUT_I: begin
        if (bus.K_IN_I_ENABLE && bus.K_IN_K_ENABLE) begin
          k_out_d = bus.K_IN;
          state_d = ENDER;
        end
      end

      INPUT_K: begin
        if (bus.K_IN_K_ENABLE) begin
          k_out_d = bus.K_IN;
          state_d = ENDER;
        end
      end

      ENDER: begin
        if (zero_q) begin
          ready_d = 1'b1;
          zero_d  = 1'b0;
          state_d = STARTER;
        end else if (!last_k) begin
          cnt_advance = 1'b1;
          req_k_d     = 1'b1;
          state_d     = INPUT_K;
        end else if (!last_i) begin
          cnt_advance = 1'b1;
          req_i_d     = 1'b1;
          req_k_d     = 1'b1;
          state_d     = INPUT_I;
        end else begin
          ready_d   = 1'b1;
          cnt_clear = 1'b1;
          state_d   = STARTER;
        end
      end

      default: state_d = STARTER;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= STARTER;
      ready_q  <= 1'b0;
      req_i_q  <= 1'b0;
      req_k_q  <= 1'b0;
      k_out_q  <= '0;
      size_r_q <= ZERO_C;
      size_w_q <= ZERO_C;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      req_i_q  <= req_i_d;
      req_k_q  <= req_k_d;
      k_out_q  <= k_out_d;
      size_r_q <= size_r_d;
      size_w_q <= size_w_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_model_read_keys.sv
// Bench for model_read_keys: directed and randomized matrix transfers with a producer
// model that answers each request strobe after a chosen or random delay.
module tb_model_read_keys;

  localparam int DW = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int total = 0;
  int bad   = 0;

  int n_ready = 0;
  int n_req_i = 0;
  int n_req_k = 0;
  int n_held  = 0;
  logic prev_i = 1'b0;
  logic prev_k = 1'b0;
  logic prev_r = 1'b0;

  model_read_keys_if #(.DATA_SIZE(DW)) bus ();

  model_read_keys #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (DW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Pulse counters and a detector for any strobe held longer than one cycle.
  always @(posedge CLK) begin
    if (bus.READY === 1'b1)          n_ready <= n_ready + 1;
    if (bus.K_OUT_I_ENABLE === 1'b1) n_req_i <= n_req_i + 1;
    if (bus.K_OUT_K_ENABLE === 1'b1) n_req_k <= n_req_k + 1;
    if ((bus.K_OUT_I_ENABLE === 1'b1 && prev_i) ||
        (bus.K_OUT_K_ENABLE === 1'b1 && prev_k) ||
        (bus.READY === 1'b1 && prev_r))
      n_held <= n_held + 1;
    prev_i <= (bus.K_OUT_I_ENABLE === 1'b1);
    prev_k <= (bus.K_OUT_K_ENABLE === 1'b1);
    prev_r <= (bus.READY === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer of an r x w matrix. Elements are base, base+1, ... when base
  // is non-zero, random otherwise. dly < 0 picks a random extra delay per element.
  task automatic transfer(input int r, input int w, input int dly, input logic [63:0] base,
                          input bit restart, input bit start_on_ready);
    logic [63:0] val;
    int rdy0, ri0, rk0, waited, d;
    val  = '0;
    rdy0 = n_ready;
    ri0  = n_req_i;
    rk0  = n_req_k;
    bus.SIZE_R_IN = 64'(r);
    bus.SIZE_W_IN = 64'(w);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int e = 0; e < r * w; e++) begin
      waited = 0;
      while (bus.K_OUT_K_ENABLE !== 1'b1 && waited < 40) begin
        step();
        waited++;
      end
      chk("req_timeout", 64'(waited < 40), 64'd1);
      if (waited >= 40) return;
      chk("req_row_start", 64'(bus.K_OUT_I_ENABLE), 64'((e % w) == 0));
      if (restart && e == 0) begin
        bus.SIZE_W_IN = 64'd7;
        bus.START = 1'b1;
      end
      step();
      bus.START = 1'b0;
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      for (int j = 0; j < d; j++) step();
      val = (base != 64'd0) ? base + 64'(e) : {$urandom, $urandom};
      bus.K_IN = val;
      bus.K_IN_K_ENABLE = 1'b1;
      bus.K_IN_I_ENABLE = ((e % w) == 0) ? 1'b1 : 1'($urandom);
      step();
      bus.K_IN_K_ENABLE = 1'b0;
      bus.K_IN_I_ENABLE = 1'b0;
      bus.K_IN = {$urandom, $urandom};
      chk("k_out", bus.K_OUT, val);
    end
    chk("ready_early", 64'(bus.READY), 64'd0);
    step();
    chk("ready", 64'(bus.READY), 64'd1);
    if (start_on_ready) begin
      bus.SIZE_R_IN = 64'd1;
      bus.SIZE_W_IN = 64'd1;
      bus.START = 1'b1;
    end
    step();
    bus.START = 1'b0;
    chk("ready_pulse", 64'(bus.READY), 64'd0);
    if (start_on_ready) chk("start_on_ready_ignored", 64'(bus.K_OUT_K_ENABLE), 64'd0);
    chk("k_out_hold", bus.K_OUT, val);
    step();
    chk("ready_count", 64'(n_ready - rdy0), 64'd1);
    chk("req_i_count", 64'(n_req_i - ri0), 64'(r));
    chk("req_k_count", 64'(n_req_k - rk0), 64'(r * w));
  endtask

  task automatic zero_xfer(input int r, input int w);
    logic [63:0] prev;
    int rdy0, rk0;
    prev = bus.K_OUT;
    rdy0 = n_ready;
    rk0  = n_req_k;
    bus.SIZE_R_IN = 64'(r);
    bus.SIZE_W_IN = 64'(w);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk("zero_no_req", 64'({bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE}), 64'd0);
    chk("zero_ready_early", 64'(bus.READY), 64'd0);
    step();
    chk("zero_ready", 64'(bus.READY), 64'd1);
    step();
    chk("zero_ready_pulse", 64'(bus.READY), 64'd0);
    chk("zero_k_out", bus.K_OUT, prev);
    step();
    chk("zero_ready_count", 64'(n_ready - rdy0), 64'd1);
    chk("zero_req_count", 64'(n_req_k - rk0), 64'd0);
  endtask

  initial begin
    logic [63:0] a_val;
    int rdy0;
    bus.START = 1'b0;
    bus.K_IN_I_ENABLE = 1'b0;
    bus.K_IN_K_ENABLE = 1'b0;
    bus.SIZE_R_IN = '0;
    bus.SIZE_W_IN = '0;
    bus.K_IN = '0;

    // Reset state
    RST = 1'b0;
    step();
    step();
    chk("rst_ready", 64'(bus.READY), 64'd0);
    chk("rst_req", 64'({bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE}), 64'd0);
    chk("rst_k_out", bus.K_OUT, 64'd0);
    RST = 1'b1;
    step();

    // R=1, W=1, immediate answer: strobes cycle 1, accept cycle 2, READY cycle 4
    bus.SIZE_R_IN = 64'd1;
    bus.SIZE_W_IN = 64'd1;
    transfer(1, 1, 0, 64'h5, 1'b0, 1'b0);

    // R=2, W=3, elements 1..6, answered 2 cycles after each strobe
    transfer(2, 3, 1, 64'h1, 1'b0, 1'b0);

    // Randomized shapes, delays and data
    for (int n = 0; n < 5; n++)
      transfer(int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1, 64'd0, 1'b0, 1'b0);

    // Protocol errors: K without I in INPUT_I, and a long silence in INPUT_K
    rdy0 = n_ready;
    bus.SIZE_R_IN = 64'd1;
    bus.SIZE_W_IN = 64'd2;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    chk("err_req_i", 64'(bus.K_OUT_I_ENABLE), 64'd1);
    step();
    a_val = bus.K_OUT;
    bus.K_IN = 64'hBAD;
    bus.K_IN_K_ENABLE = 1'b1;
    bus.K_IN_I_ENABLE = 1'b0;
    repeat (3) step();
    chk("err_k_without_i", bus.K_OUT, a_val);
    bus.K_IN_K_ENABLE = 1'b0;
    step();
    a_val = {$urandom, $urandom};
    bus.K_IN = a_val;
    bus.K_IN_K_ENABLE = 1'b1;
    bus.K_IN_I_ENABLE = 1'b1;
    step();
    bus.K_IN_K_ENABLE = 1'b0;
    bus.K_IN_I_ENABLE = 1'b0;
    chk("err_accept_first", bus.K_OUT, a_val);
    step();
    chk("err_req_k", 64'(bus.K_OUT_K_ENABLE), 64'd1);
    bus.K_IN = 64'hDEAD;
    bus.K_IN_I_ENABLE = 1'b1;
    repeat (10) step();
    chk("err_k_silent", bus.K_OUT, a_val);
    chk("err_no_ready", 64'(n_ready - rdy0), 64'd0);
    bus.K_IN_I_ENABLE = 1'b0;
    a_val = {$urandom, $urandom};
    bus.K_IN = a_val;
    bus.K_IN_K_ENABLE = 1'b1;
    step();
    bus.K_IN_K_ENABLE = 1'b0;
    chk("err_accept_second", bus.K_OUT, a_val);
    step();
    chk("err_ready", 64'(bus.READY), 64'd1);
    step();
    step();

    // Zero-size transfers
    zero_xfer(0, 4);
    zero_xfer(3, 0);

    // START re-issued mid-transfer with a different width is ignored
    transfer(1, 2, 0, 64'h20, 1'b1, 1'b0);

    // START coinciding with READY is ignored
    transfer(2, 1, -1, 64'd0, 1'b0, 1'b1);

    // Reset mid-transfer (R=2, W=2, after one accept)
    rdy0 = n_ready;
    bus.SIZE_R_IN = 64'd2;
    bus.SIZE_W_IN = 64'd2;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    bus.K_IN = 64'h11;
    bus.K_IN_K_ENABLE = 1'b1;
    bus.K_IN_I_ENABLE = 1'b1;
    step();
    bus.K_IN_K_ENABLE = 1'b0;
    bus.K_IN_I_ENABLE = 1'b0;
    chk("rst2_accept", bus.K_OUT, 64'h11);
    step();
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst2_outputs", {bus.K_OUT[60:0], bus.READY, bus.K_OUT_I_ENABLE, bus.K_OUT_K_ENABLE}, 64'd0);
    end
    RST = 1'b1;
    repeat (3) step();
    chk("rst2_no_ready", 64'(n_ready - rdy0), 64'd0);
    chk("rst2_k_out", bus.K_OUT, 64'd0);
    transfer(1, 1, 0, 64'h77, 1'b0, 1'b0);

    chk("strobes_single_cycle", 64'(n_held), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/model_read_keys.md
Name: model_read_keys

Overview:
- Reader-side counterpart of the DNC write key unit: streams the R×W read-key matrix k[i][k] of the read heads, one element per handshake, using nested row/element counters.
- Sits in the read_heads group beside read strength and read modes.
- Driven by the read_heads stimulus/controller; each accepted element is forwarded on K_OUT for the content-addressing datapath.

Parameters:
- DATA_SIZE, 64, width of key elements and size inputs.
- CONTROL_SIZE, 64, width of internal index counters.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-low.
- START  in  1  one-cycle pulse; begins a transfer, latches sizes.
- READY  out  1  one-cycle pulse when transfer completes.
- K_IN_I_ENABLE  in  1  producer marks first element of a row (head i).
- K_IN_K_ENABLE  in  1  producer marks K_IN valid (element k).
- K_OUT_I_ENABLE  out  1  request strobe: new row requested.
- K_OUT_K_ENABLE  out  1  request strobe: next element requested.
- SIZE_R_IN  in  DATA_SIZE  number of read heads R (rows).
- SIZE_W_IN  in  DATA_SIZE  word width W (elements per row).
- K_IN  in  DATA_SIZE  key element from producer.
- K_OUT  out  DATA_SIZE  last accepted key element.

Behaviour:
- Reset (RST=0 at a CLK edge): state STARTER; READY, K_OUT_I_ENABLE and K_OUT_K_ENABLE = 0; K_OUT = 0; index_i = index_k = 0; latched sizes = 0. RST low mid-transfer aborts; no READY is issued.
- FSM states:
  - STARTER: idle. READY=0. On START: latch SIZE_R_IN and SIZE_W_IN, clear indices.
    - If either size is 0: go to ENDER (zero-size transfer).
    - Otherwise: assert K_OUT_I_ENABLE and K_OUT_K_ENABLE for one cycle, go to INPUT_I.
  - INPUT_I: wait for K_IN_I_ENABLE=1 and K_IN_K_ENABLE=1 in the same cycle. On accept: K_OUT <= K_IN, then go to ENDER.
    - K_IN_K_ENABLE without K_IN_I_ENABLE: ignored.
  - INPUT_K: wait for K_IN_K_ENABLE=1 (K_IN_I_ENABLE don't-care). On accept: K_OUT <= K_IN, then go to ENDER.
  - ENDER: one-cycle evaluation of the indices.
    - Zero-size path: READY=1 for one cycle, then STARTER.
    - index_k < W-1: index_k++; pulse K_OUT_K_ENABLE; go to INPUT_K.
    - index_k = W-1 and index_i < R-1: index_k=0; index_i++; pulse K_OUT_I_ENABLE and K_OUT_K_ENABLE; go to INPUT_I.
    - index_k = W-1 and index_i = R-1: READY=1 for one cycle; indices cleared; go to STARTER.
- Request strobes are single-cycle pulses, never held. The producer may answer at the earliest in the cycle after the strobe; any wait length is allowed.
- K_OUT updates only on accept and holds otherwise. It remains valid after READY until the next accept.
- Minimum throughput: 2 cycles per element.
- Timing for R=1, W=1 with an immediate answer:
  - START at cycle 0; strobes at cycle 1.
  - Accept at cycle 2; K_OUT valid at cycle 3.
  - READY at cycle 4.
- START while not in STARTER: ignored; latched sizes are unchanged.
- START in the same cycle as READY: ignored. A new transfer requires START while in STARTER.
- Input enables in STARTER or ENDER: ignored.
- Sizes are compared as unsigned. Counters are CONTROL_SIZE wide; sizes are truncated to CONTROL_SIZE bits.

Decomposition:
- Shared package model_read_heads_pkg:
  - State enum (STARTER, INPUT_I, INPUT_K, ENDER).
  - ZERO_CONTROL and ONE_CONTROL constants.
  - Reused by read_strength and read_modes.
- One natural sub-module, model_index_2d_counter: owns index_i/index_k, the last-element flags and the advance/clear controls; reusable by other matrix streamers.

Test Plan:
- Reset: hold RST=0 for 3 cycles mid-transfer (R=2, W=2, after 1 accept) -> all outputs 0, no READY; a new START with R=1, W=1 then completes normally.
- R=1, W=1, K_IN=0x5 answered immediately -> K_OUT=0x5, READY at cycle 4, exactly one K_OUT_I_ENABLE pulse.
- R=2, W=3, elements 1..6, producer answers 2 cycles after each strobe:
  - K_OUT sequence 1..6.
  - K_OUT_I_ENABLE pulses 2×, K_OUT_K_ENABLE pulses 6×.
  - One READY.
- Protocol errors: in INPUT_I drive K_IN_K_ENABLE without K_IN_I_ENABLE, and in INPUT_K keep K_IN_K_ENABLE=0 for 10 cycles -> no accepts, K_OUT unchanged, no READY.
- Sizes R=0, W=4 -> no request strobes, READY 2 cycles after START, K_OUT unchanged.
- START re-issued during a transfer (R=1, W=2) with SIZE_W_IN=7 -> ignored; exactly 2 elements transferred.
